// File: rtl/sha3_pkg.sv
// sha3_pkg: shared constants and FSM states for the SHA3-256 message scheduler
package sha3_pkg;
  localparam int WORD_W = 64;
  localparam int RATE_W = 1088;
  localparam int RATE_BYTES = 136;
  localparam int RATE_WORDS = 17;
  localparam int DIGEST_W = 256;
  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST = 8'h80;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FILL = 3'd1;
  localparam logic [2:0] PAD = 3'd2;
  localparam logic [2:0] DISPATCH = 3'd3;
  localparam logic [2:0] WAIT_OUT = 3'd4;
endpackage

// File: rtl/sha3_msg_sched_if.sv
// sha3_msg_sched_if: message word stream, core block handshake and digest bundle
interface sha3_msg_sched_if;
  import sha3_pkg::*;
  logic [WORD_W-1:0] msg_data;
  logic msg_valid;
  logic msg_last;
  logic [3:0] msg_bytes;
  logic msg_ready;
  logic [RATE_W-1:0] core_in;
  logic core_in_valid;
  logic core_more;
  logic core_hash_next;
  logic [DIGEST_W-1:0] core_out;
  logic core_out_valid;
  logic [DIGEST_W-1:0] digest;
  logic digest_valid;
  logic busy;
  modport slave (
    input msg_data, msg_valid, msg_last, msg_bytes, core_hash_next, core_out, core_out_valid,
    output msg_ready, core_in, core_in_valid, core_more, digest, digest_valid, busy
  );
  modport master (
    output msg_data, msg_valid, msg_last, msg_bytes, core_hash_next, core_out, core_out_valid,
    input msg_ready, core_in, core_in_valid, core_more, digest, digest_valid, busy
  );
endinterface

// File: rtl/sha3_pad_gen.sv
// sha3_pad_gen: writes SHA3 0x06..0x80 padding into a rate block from byte p onward
module sha3_pad_gen
  import sha3_pkg::*;
(
  input  logic [RATE_W-1:0] blk_i,
  input  logic [7:0]        p_i,
  output logic [RATE_W-1:0] blk_o,
  output logic              ovf_o
);
  assign ovf_o = p_i >= 8'(RATE_BYTES);
  // bytes before p keep message data; p gets 0x06, the last byte has 0x80 OR'd in, the rest are zero
  always_comb begin
    blk_o = blk_i;
    for (int k = 0; k < RATE_BYTES; k++)
      if (8'(k) >= p_i)
        blk_o[RATE_W-1-8*k -: 8] = (8'(k) == p_i ? PAD_FIRST : 8'h00) | (k == RATE_BYTES - 1 ? PAD_LAST : 8'h00);
  end
endmodule

// File: rtl/sha3_msg_sched.sv
// sha3_msg_sched: packs 64-bit message words into padded 1088-bit blocks and paces them into the SHA3 core
module sha3_msg_sched
  import sha3_pkg::*;
(
  input logic clk,
  input logic rst_n,
  sha3_msg_sched_if.slave bus
);
  logic [2:0] state_q, state_d;
  logic [RATE_W-1:0] blk_q, blk_d, pad_blk;
  logic [4:0] word_cnt_q, word_cnt_d;
  logic [7:0] pad_pos_q, pad_pos_d;
  logic first_blk_q, first_blk_d;
  logic more_q, more_d;
  logic pad_pending_q, pad_pending_d;
  logic ready_q, ready_d;
  logic digest_valid_q, digest_valid_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic pad_ovf, accept, strobe;
  logic [3:0] last_bytes;

  assign last_bytes = bus.msg_bytes > 4'd8 ? 4'd8 : bus.msg_bytes;
  assign accept = bus.msg_valid & ready_q;
  assign strobe = state_q == DISPATCH && (first_blk_q || bus.core_hash_next);

  assign bus.msg_ready = ready_q;
  assign bus.core_in = blk_q;
  assign bus.core_in_valid = strobe;
  assign bus.core_more = strobe & more_q;
  assign bus.digest = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.busy = state_q != IDLE;

  sha3_pad_gen u_pad (
    .blk_i(state_q == PAD ? blk_q : '0),
    .p_i  (state_q == PAD ? pad_pos_q : 8'd0),
    .blk_o(pad_blk),
    .ovf_o(pad_ovf)
  );

  // block assembly, padding and one-block-in-flight dispatch sequencing
  always_comb begin
    state_d = state_q;
    blk_d = blk_q;
    word_cnt_d = word_cnt_q;
    pad_pos_d = pad_pos_q;
    first_blk_d = first_blk_q;
    more_d = more_q;
    pad_pending_d = pad_pending_q;
    digest_valid_d = digest_valid_q;
    digest_d = digest_q;
    case (state_q)
      IDLE, FILL: if (accept) begin
        blk_d[RATE_W-1-WORD_W*int'(word_cnt_q) -: WORD_W] = bus.msg_data;
        word_cnt_d = word_cnt_q + 5'd1;
        digest_valid_d = state_q == IDLE ? 1'b0 : digest_valid_q;
        pad_pos_d = {word_cnt_q, 3'b000} + 8'(last_bytes);
        more_d = !bus.msg_last;
        state_d = bus.msg_last ? PAD : word_cnt_q == 5'(RATE_WORDS - 1) ? DISPATCH : FILL;
      end
      PAD: begin
        blk_d = pad_blk;
        more_d = pad_ovf;
        pad_pending_d = pad_ovf;
        state_d = DISPATCH;
      end
      DISPATCH: if (strobe) begin
        first_blk_d = 1'b0;
        if (pad_pending_q) begin
          blk_d = pad_blk;
          more_d = 1'b0;
          pad_pending_d = 1'b0;
        end else if (more_q) begin
          blk_d = '0;
          word_cnt_d = 5'd0;
          state_d = FILL;
        end else state_d = WAIT_OUT;
      end
      WAIT_OUT: if (bus.core_out_valid) begin
        digest_d = bus.core_out;
        digest_valid_d = 1'b1;
        blk_d = '0;
        word_cnt_d = 5'd0;
        first_blk_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE || state_d == FILL;
  end

  // state registers, cleared asynchronously together with the core
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      blk_q <= '0;
      word_cnt_q <= '0;
      pad_pos_q <= '0;
      first_blk_q <= 1'b1;
      more_q <= 1'b0;
      pad_pending_q <= 1'b0;
      ready_q <= 1'b0;
      digest_valid_q <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q <= blk_d;
      word_cnt_q <= word_cnt_d;
      pad_pos_q <= pad_pos_d;
      first_blk_q <= first_blk_d;
      more_q <= more_d;
      pad_pending_q <= pad_pending_d;
      ready_q <= ready_d;
      digest_valid_q <= digest_valid_d;
      digest_q <= digest_d;
    end
endmodule

// File: tb/tb_sha3_msg_sched.sv
// tb_sha3_msg_sched: table-driven and randomized checks of block packing, padding and pacing
module tb_sha3_msg_sched;
  import sha3_pkg::*;

  typedef struct {
    int len;
    int gap;
    int exp_blocks;
    logic [7:0] exp_b135;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_msg_sched_if bus();
  sha3_msg_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int errs = 0, checks = 0, ready_viol = 0, acc_in_blk = 0;
  bit last_seen = 0, hn_hold = 0;
  logic [RATE_W-1:0] cap_blk[$], exp_blk[$];
  logic cap_more[$], exp_more[$];
  vec_t vecs[7];

  // core model: random hash_next pacing unless held off
  always @(posedge clk) begin
    #1;
    bus.core_hash_next = !hn_hold && ($urandom_range(0, 2) == 0);
  end

  // capture strobed blocks and watch that no word is accepted while a finished block waits
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_in_blk = 0;
      last_seen = 0;
    end else begin
      if (bus.digest_valid && !bus.busy) last_seen = 0;
      if (bus.msg_ready && (acc_in_blk == RATE_WORDS || last_seen)) ready_viol++;
      if (bus.core_in_valid) begin
        cap_blk.push_back(bus.core_in);
        cap_more.push_back(bus.core_more);
        acc_in_blk = 0;
      end
      if (bus.msg_valid && bus.msg_ready) begin
        acc_in_blk++;
        if (bus.msg_last) last_seen = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [RATE_W-1:0] got, input logic [RATE_W-1:0] exp);
    int idx;
    checks++;
    if (got !== exp) begin
      errs++;
      idx = -1;
      for (int k = RATE_BYTES - 1; k >= 0; k--)
        if (got[RATE_W-1-8*k -: 8] !== exp[RATE_W-1-8*k -: 8]) idx = k;
      $display("FAIL %s: byte %0d got %h expected %h", name, idx,
               got[RATE_W-1-8*idx -: 8], exp[RATE_W-1-8*idx -: 8]);
    end
  endtask

  // reference: append SHA3 pad (0x06 .. 0x80, or 0x86 alone) to the byte string, split into 136-byte blocks
  function automatic void build_exp(input logic [7:0] m[$]);
    logic [7:0] p[$];
    logic [RATE_W-1:0] b;
    int q, nb;
    p = m;
    q = RATE_BYTES - (m.size() % RATE_BYTES);
    if (q == 1) p.push_back(8'h86);
    else begin
      p.push_back(8'h06);
      repeat (q - 2) p.push_back(8'h00);
      p.push_back(8'h80);
    end
    nb = p.size() / RATE_BYTES;
    exp_blk.delete();
    exp_more.delete();
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < RATE_BYTES; k++) b[RATE_W-1-8*k -: 8] = p[i*RATE_BYTES+k];
      exp_blk.push_back(b);
      exp_more.push_back(i < nb - 1);
    end
  endfunction

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    bit acc = 0;
    int cyc = 0;
    bus.msg_data = d;
    bus.msg_last = last;
    bus.msg_bytes = nb;
    bus.msg_valid = 1'b1;
    while (!acc && cyc < 500) begin
      @(negedge clk);
      acc = bus.msg_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.msg_valid = 1'b0;
    bus.msg_last = 1'b0;
    if (!acc) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: msg_ready stayed 0 for %0d cycles, required 1", cyc);
    end
  endtask

  task automatic send_msg(input logic [7:0] m[$], input int gap);
    int nw, nb;
    logic [63:0] d;
    logic [3:0] bytes_in;
    nw = m.size() == 0 ? 1 : (m.size() + 7) / 8;
    nb = m.size() - 8 * (nw - 1);
    for (int w = 0; w < nw; w++) begin
      if ($urandom_range(0, 99) < gap) repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
      for (int j = 0; j < 8; j++) d[63-8*j -: 8] = (8 * w + j < m.size()) ? m[8*w+j] : 8'($urandom);
      bytes_in = w < nw - 1 ? 4'($urandom) : (nb == 8 && $urandom_range(0, 1) == 1) ? 4'($urandom_range(9, 15)) : 4'(nb);
      send_word(d, w == nw - 1, bytes_in);
      if (w == 0) chk("digest_valid_clr", 256'(bus.digest_valid), 256'(0));
    end
  endtask

  task automatic finish_msg(input string name);
    int cyc = 0;
    logic [255:0] dg;
    while (cap_blk.size() < exp_blk.size() && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk({name, "_nblk"}, 256'(cap_blk.size()), 256'(exp_blk.size()));
    for (int i = 0; i < exp_blk.size() && i < cap_blk.size(); i++) begin
      chk_blk({name, "_blk"}, cap_blk[i], exp_blk[i]);
      chk({name, "_more"}, 256'(cap_more[i]), 256'(exp_more[i]));
    end
    dg = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.core_out = dg;
    bus.core_out_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.core_out_valid = 1'b0;
    bus.core_out = {8{$urandom}};
    @(negedge clk);
    chk({name, "_digest"}, bus.digest, dg);
    chk({name, "_digest_valid"}, 256'(bus.digest_valid), 256'(1));
    chk({name, "_idle"}, 256'(bus.busy), 256'(0));
    chk({name, "_ready_hold"}, 256'(ready_viol), 256'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input int len, output logic [7:0] m[$]);
    m.delete();
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    ready_viol = 0;
    cap_blk.delete();
    cap_more.delete();
    build_exp(m);
  endtask

  initial begin
    logic [7:0] m[$];
    logic [RATE_W-1:0] b;
    logic [23:0] pre;
    vecs[0] = '{0, 0, 1, 8'h80};
    vecs[1] = '{3, 0, 1, 8'h80};
    vecs[2] = '{135, 0, 1, 8'h86};
    vecs[3] = '{300, 30, 3, 8'h80};
    vecs[4] = '{8, 10, 1, 8'h80};
    vecs[5] = '{271, 20, 2, 8'h86};
    vecs[6] = '{272, 0, 3, 8'h80};
    bus.msg_data = '0;
    bus.msg_valid = 1'b0;
    bus.msg_last = 1'b0;
    bus.msg_bytes = '0;
    bus.core_out = '0;
    bus.core_out_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 256'(bus.msg_ready), 256'(0));
    chk_blk("rst_core_in", bus.core_in, '0);
    chk("rst_in_valid", 256'(bus.core_in_valid), 256'(0));
    chk("rst_more", 256'(bus.core_more), 256'(0));
    chk("rst_digest", bus.digest, 256'(0));
    chk("rst_digest_valid", 256'(bus.digest_valid), 256'(0));
    chk("rst_busy", 256'(bus.busy), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    for (int v = 0; v < 7; v++) begin
      start_msg(vecs[v].len, m);
      if (vecs[v].len == 3) begin
        m = '{8'h61, 8'h62, 8'h63};
        build_exp(m);
      end
      send_msg(m, vecs[v].gap);
      finish_msg($sformatf("len%0d", vecs[v].len));
      chk($sformatf("len%0d_blocks", vecs[v].len), 256'(cap_blk.size()), 256'(vecs[v].exp_blocks));
      b = cap_blk.size() > 0 ? cap_blk[cap_blk.size()-1] : '0;
      chk($sformatf("len%0d_byte135", vecs[v].len), 256'(b[7:0]), 256'(vecs[v].exp_b135));
      if (vecs[v].len == 3) begin
        pre = b[RATE_W-1 -: 24];
        chk("abc_prefix", 256'(pre), 256'(24'h616263));
        chk("abc_byte3", 256'(b[RATE_W-25 -: 8]), 256'(8'h06));
      end
    end

    start_msg(136, m);
    hn_hold = 1'b1;
    send_msg(m, 0);
    for (int c = 0; c < 50 && cap_blk.size() < 1; c++) begin
      @(posedge clk);
      #1;
    end
    bus.core_out = '1;
    bus.core_out_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.core_out_valid = 1'b0;
    repeat (24) begin
      @(posedge clk);
      #1;
    end
    chk("hold_one_strobe", 256'(cap_blk.size()), 256'(1));
    chk("hold_busy", 256'(bus.busy), 256'(1));
    hn_hold = 1'b0;
    finish_msg("len136");

    start_msg(120, m);
    for (int w = 0; w < 9; w++) send_word({m[8*w], m[8*w+1], m[8*w+2], m[8*w+3], m[8*w+4], m[8*w+5], m[8*w+6], m[8*w+7]}, 1'b0, 4'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 256'(bus.msg_ready), 256'(0));
    chk_blk("midrst_core_in", bus.core_in, '0);
    chk("midrst_digest", bus.digest, 256'(0));
    chk("midrst_digest_valid", 256'(bus.digest_valid), 256'(0));
    chk("midrst_busy", 256'(bus.busy), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start_msg(150, m);
    send_msg(m, 25);
    finish_msg("after_rst");

    for (int r = 0; r < 6; r++) begin
      start_msg($urandom_range(0, 420), m);
      send_msg(m, $urandom_range(0, 40));
      finish_msg($sformatf("rnd%0d_len%0d", r, m.size()));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
